multicycle_control_fsm: RTL and testbench

Multicycle sequencing controller for the MIPS-32 core. Replaces single-cycle opcode decoding with a Moore/Mealy state machine that steps a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and write-back. It waits on a memory-ready handshake and flags unsupported opcodes. It sits between the instruction register opcode field and all datapath mux and write-enable controls.

---
 rtl/multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// This is the sequencing controller for the multicycle MIPS-32 datapath, which
// shares one ALU and one memory. It steps each instruction through fetch,
// decode, execute, memory and write-back. It waits on the memory-ready
// handshake in FETCH, MEMRD and MEMWR, and it pulses IllegalOp when DECODE
// sees an unsupported opcode.
//
// State | meaning
// ------+----------------------------------------------------------------
// START | after reset, all controls idle (code 12)
// FETCH | read instruction, PC += 4 when MemReady (code 0)
// DECODE| latch opcode, compute branch target into ALUOut (code 1)
// MEMADR| compute lw/sw effective address (code 2)
// MEMRD | data read, wait for MemReady (code 3)
// MEMWB | load result written to rt (code 4)
// MEMWR | data write, wait for MemReady (code 5)
// EXEC  | R-type ALU operation (code 6)
// ALUWB | R-type result written to rd (code 7)
// BRANCH| beq compare, conditional PC write (code 8)
// JUMP  | j / jal, PC <= jump target (code 9)
// ADDIEX| addi ALU operation (code 10)
// ADDIWB| addi result written to rt (code 11)
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   OpCode[5:0]           instruction[31:26], valid from DECODE onward
//   Zero                  ALU zero flag (used by external PC-enable logic)
//   MemReady              memory access complete handshake
//   PCWrite .. JAL        1-bit datapath mux selects / write enables
//   ALUSrcB, ALUOp,
//   PCSource [1:0]        datapath mux selects
//   InstrDone             pulse in the last cycle of each instruction
//   IllegalOp             pulse in DECODE for an unsupported opcode
//   State[3:0]            current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_control_fsm (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       JAL,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_START  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;

  // Zero is consumed outside this block together with PCWriteCond.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_START;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= OpCode;
      end
    end
  end

  // In DECODE the next state comes from the live OpCode. Everything after
  // DECODE uses op_q, so the IR field may change without disturbing the
  // instruction that is already in flight.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    JAL         = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    InstrDone   = 1'b0;
    IllegalOp   = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op_q == OP_LW)      state_d = S_MEMRD;
        else if (op_q == OP_SW) state_d = S_MEMWR;
        else                    state_d = S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
        InstrDone   = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCSource  = 2'b10;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
        if (op_q == OP_JAL) begin
          JAL      = 1'b1;
          RegWrite = 1'b1;
        end
        state_d = S_FETCH;
      end
      default: begin
        // Codes 13-15 are unreachable. Recover to START with all controls idle.
        state_d = S_START;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// This is a directed, self-checking bench for multicycle_control_fsm. Inputs
// change on the falling edge of Clk. Outputs are sampled 1 ns after that edge,
// which is well away from the rising edge. The cycle numbers in the tasks
// count from the first FETCH cycle, which is cycle 1.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [5:0] OpCode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, JAL;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       InstrDone, IllegalOp;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  multicycle_control_fsm dut (
    .Clk(Clk), .Reset_n(Reset_n), .OpCode(OpCode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .JAL(JAL), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
    .State(State)
  );

  // Reset for two cycles, then release. The next negedge is cycle 1 (FETCH).
  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] all_out;
    Reset_n  = 1'b0;
    MemReady = 1'b0;
    OpCode   = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      all_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                 RegDst, RegWrite, ALUSrcA, JAL, ALUSrcB != 2'b00, ALUOp != 2'b00,
                 PCSource != 2'b00, InstrDone, IllegalOp};
      n_checks++;
      if (State !== 4'd12 || all_out !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: State=%0d outs=%b, required State=12 outs=0", i, State, all_out);
      end
    end
    Reset_n = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge Clk); #1;
      n_checks++;
      if (State !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_wait cyc%0d: State=%0d MemRead=%b IRWrite=%b PCWrite=%b, required 0/1/0/0",
                 c, State, MemRead, IRWrite, PCWrite);
      end
    end
    @(negedge Clk);
    MemReady = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_ready: State=%0d IRWrite=%b PCWrite=%b, required 0/1/1", State, IRWrite, PCWrite);
    end
    @(negedge Clk); #1;
    n_checks++;
    if (State !== 4'd1) begin
      n_fail++;
      $display("FAIL fetch_to_decode: State=%0d, required 1", State);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops  [6] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    int         done [6] = '{4, 8, 13, 17, 20, 23};
    int k = 0;
    logic exp_rw;
    MemReady = 1'b1;
    OpCode   = ops[0];
    do_reset();
    for (int c = 1; c <= 30 && k < 6; c++) begin
      @(negedge Clk);
      OpCode = ops[k];
      #1;
      exp_rw = (c == 4) || (c == 8) || (c == 13);
      n_checks++;
      if (RegWrite !== exp_rw) begin
        n_fail++;
        $display("FAIL b2b_regwrite cyc%0d: RegWrite=%b, required %b", c, RegWrite, exp_rw);
      end
      n_checks++;
      if (MemRead === 1'b1 && MemWrite === 1'b1) begin
        n_fail++;
        $display("FAIL b2b_mem_excl cyc%0d: MemRead=1 MemWrite=1, required not both", c);
      end
      if (InstrDone === 1'b1) begin
        n_checks++;
        if (c != done[k]) begin
          n_fail++;
          $display("FAIL b2b_done op%0d: InstrDone at cycle %0d, required %0d", k, c, done[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 6) begin
      n_fail++;
      $display("FAIL b2b_count: %0d instructions completed, required 6", k);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    OpCode   = 6'b100011;
    MemReady = 1'b1;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      MemReady = !(c >= 4 && c <= 6);
      #1;
      n_checks++;
      if (State !== exp_st[c-1] || IorD !== (c >= 4 && c <= 7) ||
          MemToReg !== (c == 8) || InstrDone !== (c == 8)) begin
        n_fail++;
        $display("FAIL lw_stall cyc%0d: State=%0d IorD=%b MemToReg=%b InstrDone=%b, required State=%0d IorD=%b MemToReg=%b InstrDone=%b",
                 c, State, IorD, MemToReg, InstrDone, exp_st[c-1], (c >= 4 && c <= 7), (c == 8), (c == 8));
      end
    end
  endtask

  task automatic test_jal();
    MemReady = 1'b1;
    OpCode   = 6'b000011;
    do_reset();
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    OpCode = 6'b000000;
    #1;
    n_checks++;
    if (State !== 4'd9 || PCSource !== 2'b10 || PCWrite !== 1'b1 || JAL !== 1'b1 ||
        RegWrite !== 1'b1 || InstrDone !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_jump: State=%0d PCSource=%b PCWrite=%b JAL=%b RegWrite=%b InstrDone=%b, required 9/10/1/1/1/1",
               State, PCSource, PCWrite, JAL, RegWrite, InstrDone);
    end
    @(negedge Clk);
    OpCode = 6'b000010;
    @(negedge Clk);
    @(negedge Clk); #1;
    n_checks++;
    if (State !== 4'd9 || PCSource !== 2'b10 || PCWrite !== 1'b1 || JAL !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL j_jump: State=%0d PCSource=%b PCWrite=%b JAL=%b RegWrite=%b, required 9/10/1/0/0",
               State, PCSource, PCWrite, JAL, RegWrite);
    end
  endtask

  task automatic test_illegal();
    MemReady = 1'b1;
    OpCode   = 6'b111111;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk); #1;
      n_checks++;
      if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_writes cyc%0d: RegWrite=%b MemWrite=%b, required 0/0", c, RegWrite, MemWrite);
      end
      if (c == 2) begin
        n_checks++;
        if (State !== 4'd1 || IllegalOp !== 1'b1 || InstrDone !== 1'b1) begin
          n_fail++;
          $display("FAIL illegal_decode: State=%0d IllegalOp=%b InstrDone=%b, required 1/1/1", State, IllegalOp, InstrDone);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (State !== 4'd0 || IllegalOp !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal_next: State=%0d IllegalOp=%b, required 0/0", State, IllegalOp);
        end
      end
    end
  endtask

  task automatic test_opcode_change_and_abort();
    MemReady = 1'b1;
    OpCode   = 6'b100011;
    do_reset();
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    OpCode = 6'b101011;
    #1;
    n_checks++;
    if (State !== 4'd2) begin
      n_fail++;
      $display("FAIL memadr_state: State=%0d, required 2", State);
    end
    @(negedge Clk); #1;
    n_checks++;
    if (State !== 4'd3 || MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL latched_lw: State=%0d MemWrite=%b, required 3/0", State, MemWrite);
    end

    OpCode = 6'b101011;
    do_reset();
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    MemReady = 1'b0;
    #1;
    n_checks++;
    if (State !== 4'd5 || MemWrite !== 1'b1 || InstrDone !== 1'b0) begin
      n_fail++;
      $display("FAIL memwr_wait: State=%0d MemWrite=%b InstrDone=%b, required 5/1/0", State, MemWrite, InstrDone);
    end
    #1;
    MemReady = 1'b1;
    Reset_n  = 1'b0;
    #1;
    n_checks++;
    if (State !== 4'd12 || MemWrite !== 1'b0 || InstrDone !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_memwr: State=%0d MemWrite=%b InstrDone=%b RegWrite=%b, required 12/0/0/0",
               State, MemWrite, InstrDone, RegWrite);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk); #1;
    n_checks++;
    if (State !== 4'd0 || MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart: State=%0d MemWrite=%b, required 0/0", State, MemWrite);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n  = 1'b0;
    OpCode   = 6'd0;
    Zero     = 1'b0;
    MemReady = 1'b0;
    test_reset();
    test_back_to_back();
    test_lw_stall();
    test_jal();
    test_illegal();
    test_opcode_change_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
